// File: rtl/uart_tx_arb_pkg.sv
// Shared types and width helpers for the UART transmit arbiter.
// The arbiter and its round-robin picker both import this package.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_e;

  localparam int DEFAULT_N_REQ = 4;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ.
module rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  localparam int PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             valid,
  output logic [PW-1:0]    idx,
  output logic [N_REQ-1:0] onehot
);

  // Rotated view: rot[gi] is the request sitting gi positions after ptr.
  logic [N_REQ-1:0] rot;
  logic [PW-1:0]    src [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [PW:0] sum;
      assign sum     = {1'b0, ptr} + (PW+1)'(gi);
      assign src[gi] = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : PW'(sum);
      assign rot[gi] = req[src[gi]];
    end
  endgenerate

  // Descending scan so the lowest rotated position (nearest to ptr) wins.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        idx   = src[k];
      end
    end
    if (valid) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte UART transmitter among N_REQ requesters: round-robin grant,
// launch, wait for completion or timeout, acknowledge, then an enforced idle gap.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ          = DEFAULT_N_REQ,
  parameter int GAP_CYCLES     = 25000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic               clk_Tx,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               busy,
  output logic               err_timeout,
  output logic [2:0]         err_id
);

  localparam int PW = $clog2(N_REQ);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);

  arb_state_e       state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    grant_idx_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] req_ack_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic             busy_q;
  logic             err_timeout_q;
  logic [2:0]       err_id_q;
  logic [TW-1:0]    tmo_cnt_q;
  logic [GW-1:0]    gap_cnt_q;

  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic [PW-1:0]    ptr_d;
  logic             tmo_expire;
  logic             frame_end;
  logic [7:0]       req_bytes [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign ptr_d = (grant_idx_q == PW'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;

  // Expires on the edge where the counter would reach TIMEOUT_CYCLES, so the
  // counter itself tops out one below the limit and cannot wrap.
  assign tmo_expire = ({1'b0, tmo_cnt_q} + 1'b1) >= (TW+1)'(TIMEOUT_CYCLES);
  assign frame_end  = tx_done | tmo_expire;

  always_ff @(posedge clk_Tx or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      grant_q       <= '0;
      req_ack_q     <= '0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_id_q      <= '0;
      tmo_cnt_q     <= '0;
      gap_cnt_q     <= '0;
    end else begin
      tx_start_q    <= 1'b0;
      req_ack_q     <= '0;
      err_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q     <= pick_onehot;
            grant_idx_q <= pick_idx;
            tx_data_q   <= req_bytes[pick_idx];
            tx_start_q  <= 1'b1;
            tmo_cnt_q   <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          if (frame_end) begin
            grant_q <= '0;
            ptr_q   <= ptr_d;
            // Completion takes priority over a coincident timeout.
            if (tx_done) begin
              req_ack_q <= grant_q;
            end else begin
              err_timeout_q <= 1'b1;
              err_id_q      <= 3'(grant_idx_q);
            end
            if (GAP_CYCLES == 0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= GW'(GAP_CYCLES);
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if ((state_q == ST_WAIT_BUSY) && tx_busy) begin
              state_q <= ST_WAIT_DONE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q <= GW'(1)) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            gap_cnt_q <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack     = req_ack_q;
  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_id      = err_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a frame table (round-robin, fast serializer,
// timeout) plus hand sequences for gap spacing and mid-frame reset.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int G = 4;
  localparam int T = 50;

  logic           clk_Tx = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           tx_done;
  logic           busy;
  logic           err_timeout;
  logic [2:0]     err_id;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_Tx      (clk_Tx),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_id      (err_id)
  );

  always #5 clk_Tx = ~clk_Tx;

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  int n_ack   = 0;
  int n_to    = 0;

  always @(posedge clk_Tx) begin
    if (tx_start)    n_start++;
    if (|req_ack)    n_ack++;
    if (err_timeout) n_to++;
  end

  // mode: 0 = normal serializer, 1 = done without busy, 2 = never done
  typedef struct {
    logic [3:0] mask;
    int         mode;
    bit         drop;
    int         exp_idx;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_Tx);
    #1;
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!tx_start && n < 200) begin
      tick;
      n++;
    end
    chk({name, " start seen"}, 32'(tx_start), 32'd1);
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy && n < 200) begin
      tick;
      n++;
    end
    chk({name, " idle reached"}, 32'(busy), 32'd0);
  endtask

  task automatic do_frame(input vec_t v, input int id);
    int    n;
    int    s0, a0, t0;
    string nm;
    nm = $sformatf("v%0d", id);
    req = v.mask;
    s0 = n_start;
    a0 = n_ack;
    t0 = n_to;
    wait_start(nm);
    chk({nm, " grant"}, 32'(grant), 32'd1 << v.exp_idx);
    chk({nm, " tx_data"}, 32'(tx_data), 32'(v.exp_data));
    chk({nm, " busy"}, 32'(busy), 32'd1);
    if (v.drop) req[v.exp_idx] = 1'b0;
    case (v.mode)
      0: begin
        tick;
        chk({nm, " start pulse"}, 32'(tx_start), 32'd0);
        tick;
        tx_busy = 1'b1;
        repeat (19) tick;
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
      end
      1: begin
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
      end
      default: begin
        tx_busy = 1'b1;
        n = 0;
        while (!err_timeout && n < 100) begin
          tick;
          n++;
        end
        tx_busy = 1'b0;
        chk({nm, " timeout latency"}, 32'(n), 32'(T));
        chk({nm, " err_id"}, 32'(err_id), 32'(v.exp_idx));
      end
    endcase
    if (v.mode == 2) begin
      chk({nm, " no ack"}, 32'(req_ack), 32'd0);
    end else begin
      chk({nm, " req_ack"}, 32'(req_ack), 32'd1 << v.exp_idx);
      chk({nm, " err_timeout"}, 32'(err_timeout), 32'd0);
    end
    chk({nm, " grant cleared"}, 32'(grant), 32'd0);
    chk({nm, " busy in gap"}, 32'(busy), 32'd1);
    req[v.exp_idx] = 1'b0;
    wait_idle(nm, n);
    chk({nm, " gap length"}, 32'(n), 32'(G));
    chk({nm, " start count"}, 32'(n_start - s0), 32'd1);
    chk({nm, " ack count"}, 32'(n_ack - a0), (v.mode == 2) ? 32'd0 : 32'd1);
    chk({nm, " timeout count"}, 32'(n_to - t0), (v.mode == 2) ? 32'd1 : 32'd0);
    $display("frame %0d: req=%b grant_idx=%0d data=%h mode=%0d", id, v.mask, v.exp_idx, v.exp_data, v.mode);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Requester bytes: 0 -> 11, 1 -> 5A, 2 -> A5, 3 -> 3C
    req_data = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    req      = '0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    rst      = 1'b1;

    // Pointer evolution starts at 0; expected indices follow the round-robin rule.
    tbl[0]  = '{4'b0100, 0, 1'b1, 2, 8'hA5};
    tbl[1]  = '{4'b1111, 0, 1'b0, 3, 8'h3C};
    tbl[2]  = '{4'b1111, 0, 1'b0, 0, 8'h11};
    tbl[3]  = '{4'b1111, 0, 1'b0, 1, 8'h5A};
    tbl[4]  = '{4'b1111, 0, 1'b0, 2, 8'hA5};
    tbl[5]  = '{4'b1111, 0, 1'b0, 3, 8'h3C};
    tbl[6]  = '{4'b1111, 0, 1'b0, 0, 8'h11};
    tbl[7]  = '{4'b0010, 1, 1'b0, 1, 8'h5A};
    tbl[8]  = '{4'b0100, 2, 1'b0, 2, 8'hA5};
    tbl[9]  = '{4'b1101, 0, 1'b0, 3, 8'h3C};
    tbl[10] = '{4'b0101, 1, 1'b0, 0, 8'h11};
    tbl[11] = '{4'b0100, 0, 1'b0, 2, 8'hA5};

    #12;
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    chk("reset tx_start", 32'(tx_start), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err_id", 32'(err_id), 32'd0);
    @(negedge clk_Tx);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 12; i++) begin
      do_frame(tbl[i], i);
    end

    // Gap spacing: ptr is 3 here, so requester 0 is served, then 1 after the gap.
    req = 4'b0001;
    wait_start("gap0");
    chk("gap0 grant", 32'(grant), 32'd1);
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("gap0 req_ack", 32'(req_ack), 32'd1);
    req = 4'b0000;
    tick;
    req = 4'b0010;
    n = 1;
    while (!tx_start && n < 100) begin
      tick;
      n++;
    end
    chk("gap spacing", 32'(n), 32'(G + 1));
    chk("gap1 grant", 32'(grant), 32'd2);
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    req = 4'b0000;
    wait_idle("gap1", n);
    $display("gap sequence: second start %0d cycles after ack", G + 1);

    // Reset in WAIT_DONE; err_id holds 2 from the earlier timeout, ptr is 2.
    req = 4'b0100;
    wait_start("rst0");
    chk("rst0 grant", 32'(grant), 32'd4);
    tx_busy = 1'b1;
    tick;
    tick;
    #2;
    rst = 1'b1;
    #1;
    chk("async grant", 32'(grant), 32'd0);
    chk("async tx_data", 32'(tx_data), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async err_id", 32'(err_id), 32'd0);
    chk("async req_ack", 32'(req_ack), 32'd0);
    chk("async err_timeout", 32'(err_timeout), 32'd0);
    tx_busy = 1'b0;
    req = 4'b1001;
    @(negedge clk_Tx);
    rst = 1'b0;
    wait_start("rst1");
    chk("rst1 grant ptr from 0", 32'(grant), 32'd1);
    chk("rst1 tx_data", 32'(tx_data), 32'h11);
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    req = 4'b1000;
    wait_idle("rst1", n);
    wait_start("rst2");
    chk("rst2 grant", 32'(grant), 32'd8);
    chk("rst2 tx_data", 32'(tx_data), 32'h3C);
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("rst2 req_ack", 32'(req_ack), 32'd8);
    req = 4'b0000;
    wait_idle("rst2", n);
    $display("reset sequence: served requesters 0 then 3 after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
